keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Parametrised matrix keypad scanner: drives columns one-hot active-low, samples active-low rows, debounces every key individually, and emits press/release events through a small FIFO with a valid/ready handshake.
- Sits between the board keypad pins and game logic, generalising the fixed 3x3 single-key controller to ROWS x COLS keys.
- Adds release events, multi-key support, buffering and overflow reporting.

Parameters:
- ROWS, 3, number of row inputs (>=1)
- COLS, 3, number of column outputs (>=2)
- SCAN_DIV, 5000, clk cycles per column slot; must be >= ROWS+3
- DEB_SCANS, 4, consecutive differing samples needed to accept a key change (>=1)
- FIFO_DEPTH, 4, event FIFO entries; power of two, >=2
- KEY_W, $clog2(ROWS*COLS), key index width (derived localparam)

Ports:
- clk  in  1  system clock (50 MHz board clock)
- reset  in  1  reset is asynchronous and active-low
- row  in  ROWS  keypad rows, active-low (0 = key closed in driven column)
- column  out  COLS  column drive, active-low one-hot
- ev_valid  out  1  FIFO head holds an event
- ev_ready  in  1  consumer accepts head this cycle
- ev_key  out  KEY_W  key index of head event = r*COLS + c
- ev_press  out  1  1 = press, 0 = release
- key_state  out  ROWS*COLS  debounced state, bit k = 1 while key k is held
- overflow  out  1  sticky: an event was dropped because the FIFO was full

Behaviour:
- Reset (async, reset=0) values:
  - prescaler=0; col_idx=0; column = all ones except bit0 = 0
  - sync flops all 1; key_state=0; debounce counters=0; pending=0
  - FIFO empty; ev_valid=0; ev_key=0; ev_press=0; overflow=0
  - Reset mid-operation discards all state and queued events; no event is emitted for keys held across reset until they re-debounce.
- Synchroniser: row passes through a 2-flop synchroniser (row_s), which resets to all 1.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - tick = (prescaler == SCAN_DIV-1).
- Sampling and column step:
  - On the tick cycle, sample row_s for the current col_idx, then advance col_idx, wrapping COLS-1 -> 0.
  - column = ~(1 << col_idx), registered; it changes on the cycle after tick.
  - Each column therefore settles for SCAN_DIV-1 cycles before it is sampled.
- Debounce, per key k in the sampled column (raw = ~row_s[r]):
  - raw == key_state[k]: cnt[k] <= 0.
  - raw != key_state[k] and cnt[k] == DEB_SCANS-1: key_state[k] toggles, cnt[k] <= 0, pending[k] <= 1, pdir[k] <= raw.
  - Otherwise: cnt[k] <= cnt[k]+1.
  - A change is therefore accepted on the DEB_SCANS-th consecutive differing sample, one sample per full scan (COLS*SCAN_DIV cycles).
- Serialiser:
  - Each cycle with pending != 0, the lowest-index pending key is pushed as {k, pdir[k]} and its pending bit is cleared.
  - At most ROWS pushes follow one tick, so the serialiser drains before the next tick.
- FIFO:
  - push is accepted if not full, or if a pop occurs in the same cycle.
  - If full with no pop, the event is dropped, overflow <= 1 (sticky until reset), and the pending bit is still cleared.
  - pop = ev_valid & ev_ready.
  - ev_valid = !empty. ev_key and ev_press show the head and are 0 while empty.
  - Order is strictly first-in first-out.
- Latency:
  - Acceptance on tick cycle T -> push in cycle T+1 -> ev_valid=1 in T+2 (FIFO previously empty).
  - The k-th simultaneous event becomes visible at T+1+k.
- Simultaneous events: several rows in one column may change on the same tick; events are queued in ascending key index.
- Push and pop in the same cycle with the FIFO empty: no bypass; the pushed event appears the next cycle.

Decomposition:
- Shared header keypad_defs.vh holds:
  - the event field layout: KEY_W + 1 bits, press flag in the LSB
  - default scan constants for the 50 MHz board
- Sub-module key_event_fifo(clk, reset, push, din, pop, dout, empty, full): synchronous FIFO, pointer-based, parametrised by WIDTH and DEPTH.
- Prescaler, column counter, debounce array and serialiser stay in keypad_scanner.

Test Plan (ROWS=3, COLS=3, SCAN_DIV=8, DEB_SCANS=3, FIFO_DEPTH=4; one scan = 24 cycles):
- Reset, row=3'b111 -> column=110 after reset; column steps 101, 011, 110 every 8 cycles; ev_valid stays 0 and key_state stays 0.
- Hold row[1]=0 whenever column[2]=0 (key 5) -> on the 3rd sampling tick key_state[5]=1; 2 cycles later ev_valid=1, ev_key=5, ev_press=1; with ev_ready=1 ev_valid drops the next cycle.
- Key 5 closed for 2 scans, then open -> no event, key_state[5] stays 0.
- Keys 0 and 3 held together (column 0, rows 0 and 1), ev_ready=0 -> FIFO holds (0,1) then (3,1); releasing both later queues (0,0) then (3,0).
- ev_ready=0, generate 5 events -> 4 are queued, 5th dropped, overflow=1; draining yields the first 4 in order; overflow remains 1.
- Assert reset mid-hold of key 5 with 2 events queued -> ev_valid=0, key_state=0, overflow=0 immediately; still held after release -> a fresh press of key 5 after 3 scans.

Source files
------------

// File: rtl/keypad_scanner_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// keypad_scanner_pkg
// Shared constants for the matrix keypad scanner: board default scan
// constants, event word layout and a width helper.
// Rev 1.0
// ---------------------------------------------------------------------------
package keypad_scanner_pkg;

  // Default scan constants for the 50 MHz board (100 us per column slot)
  localparam int DEF_ROWS       = 3;
  localparam int DEF_COLS       = 3;
  localparam int DEF_SCAN_DIV   = 5000;
  localparam int DEF_DEB_SCANS  = 4;
  localparam int DEF_FIFO_DEPTH = 4;

  // Event word layout: {key index, press flag}, press flag in the LSB
  localparam int EV_PRESS_BIT = 0;

  // Bits needed to hold the values 0..n-1, never less than one
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_event_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// key_event_fifo
// Pointer-based synchronous FIFO for key events. A push into a full FIFO is
// accepted only when a pop happens in the same cycle. Head reads as zero
// while empty.
// Rev 1.0
// ---------------------------------------------------------------------------
module key_event_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_pop;
  logic             do_push;

  // Extra wrap bit on each pointer distinguishes full from empty
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; storage is left unreset since the head is gated by empty
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ---------------------------------------------------------------------------
// keypad_scanner
// ROWS x COLS matrix keypad scanner: active-low one-hot column drive,
// synchronised active-low rows, per-key debounce, press/release events
// queued in a FIFO with valid/ready handshake and sticky overflow flag.
// Rev 1.0
// ---------------------------------------------------------------------------
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter  int ROWS       = DEF_ROWS,
  parameter  int COLS       = DEF_COLS,
  parameter  int SCAN_DIV   = DEF_SCAN_DIV,
  parameter  int DEB_SCANS  = DEF_DEB_SCANS,
  parameter  int FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int KEY_W      = $clog2(ROWS * COLS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ROWS-1:0]      row,
  output logic [COLS-1:0]      column,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic [KEY_W-1:0]     ev_key,
  output logic                 ev_press,
  output logic [ROWS*COLS-1:0] key_state,
  output logic                 overflow
);

  localparam int NKEYS = ROWS * COLS;
  localparam int PW    = width_of(SCAN_DIV);
  localparam int CW    = width_of(COLS);
  localparam int DW    = width_of(DEB_SCANS);
  localparam int EW    = KEY_W + 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_SCANS - 1);

  logic [PW-1:0]    prescaler;
  logic             tick;
  logic [CW-1:0]    col_idx;
  logic [CW-1:0]    next_col;
  logic [ROWS-1:0]  row_m;
  logic [ROWS-1:0]  row_s;
  logic [DW-1:0]    cnt [NKEYS];
  logic [NKEYS-1:0] pending;
  logic [NKEYS-1:0] pdir;
  logic [NKEYS-1:0] sel_mask;
  logic [KEY_W-1:0] sel_key;
  logic             push;
  logic [EW-1:0]    push_data;
  logic [EW-1:0]    head;
  logic             fifo_empty;
  logic             fifo_full;
  logic             pop;

  assign tick     = (prescaler == PRE_LAST);
  assign next_col = (col_idx == COL_LAST) ? '0 : col_idx + 1'b1;

  // Prescaler and column stepper; column drive follows col_idx one cycle after tick
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescaler <= '0;
      col_idx   <= '0;
      column    <= {{(COLS-1){1'b1}}, 1'b0};
    end else if (tick) begin
      prescaler <= '0;
      col_idx   <= next_col;
      column    <= ~(COLS'(1) << next_col);
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // Two-flop synchroniser for the asynchronous row pins (idle high)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_m <= '1;
      row_s <= '1;
    end else begin
      row_m <= row;
      row_s <= row_m;
    end
  end

  // Debounce the sampled column on each tick and mark accepted changes pending
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_state <= '0;
      pending   <= '0;
      pdir      <= '0;
      for (int k = 0; k < NKEYS; k++) cnt[k] <= '0;
    end else begin
      // the serialiser retires one pending key per cycle
      pending <= pending & ~sel_mask;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if (tick && (col_idx == CW'(c))) begin
            if (!row_s[r] == key_state[r*COLS + c]) begin
              cnt[r*COLS + c] <= '0;
            end else if (cnt[r*COLS + c] == DEB_LAST) begin
              key_state[r*COLS + c] <= !row_s[r];
              cnt[r*COLS + c]       <= '0;
              pending[r*COLS + c]   <= 1'b1;
              pdir[r*COLS + c]      <= !row_s[r];
            end else begin
              cnt[r*COLS + c] <= cnt[r*COLS + c] + 1'b1;
            end
          end
        end
      end
    end
  end

  // Pick the lowest-index pending key; mask isolates the lowest set bit
  always_comb begin
    sel_key = '0;
    for (int k = NKEYS - 1; k >= 0; k--) begin
      if (pending[k]) sel_key = KEY_W'(k);
    end
  end

  assign sel_mask  = pending & (~pending + NKEYS'(1));
  assign push      = |pending;
  assign push_data = {sel_key, pdir[sel_key]};
  assign pop       = ev_valid && ev_ready;

  key_event_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (push_data),
    .pop   (pop),
    .dout  (head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign ev_valid = !fifo_empty;
  assign ev_press = head[EV_PRESS_BIT];
  assign ev_key   = head[EV_PRESS_BIT+1 +: KEY_W];

  // Sticky flag for an event dropped into a full FIFO with no pop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      overflow <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_keypad_scanner
// Directed bench for a 3x3 scanner with SCAN_DIV=8, DEB_SCANS=3,
// FIFO_DEPTH=4 (one full scan = 24 clocks). A keypad model closes row r
// while column c is driven low and key r*3+c is held.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] row;
  logic [2:0] column;
  logic       ev_valid;
  logic       ev_ready;
  logic [3:0] ev_key;
  logic       ev_press;
  logic [8:0] key_state;
  logic       overflow;

  logic [8:0] held;
  int         total = 0;
  int         bad   = 0;
  int         edges = 0;

  keypad_scanner #(
    .ROWS       (3),
    .COLS       (3),
    .SCAN_DIV   (8),
    .DEB_SCANS  (3),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .column    (column),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_key    (ev_key),
    .ev_press  (ev_press),
    .key_state (key_state),
    .overflow  (overflow)
  );

  // 100 MHz bench clock
  always #5 clk = ~clk;

  // Keypad matrix model
  always_comb begin
    row = 3'b111;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        if (!column[c] && held[r*3 + c]) row[r] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  // Move to just after a column-2 sample edge (edges multiple of 24)
  task automatic align_scan();
    step((24 - (edges % 24)) % 24);
  endtask

  task automatic pop_one();
    ev_ready = 1'b1;
    step(1);
    ev_ready = 1'b0;
  endtask

  task automatic chk_head(input string tag, input int key, input logic press);
    chk({tag, "_valid"}, 32'(ev_valid), 32'd1);
    chk({tag, "_key"},   32'(ev_key),   32'(key));
    chk({tag, "_press"}, 32'(ev_press), 32'(press));
  endtask

  initial begin
    reset    = 1'b0;
    ev_ready = 1'b0;
    held     = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    // reset state
    chk("rst_column",  32'(column),    32'h6);
    chk("rst_valid",   32'(ev_valid),  32'd0);
    chk("rst_key",     32'(ev_key),    32'd0);
    chk("rst_press",   32'(ev_press),  32'd0);
    chk("rst_state",   32'(key_state), 32'd0);
    chk("rst_ovf",     32'(overflow),  32'd0);
    @(negedge clk);
    reset = 1'b1;
    edges = 0;

    // column stepping with no keys
    step(7);
    chk("col0_hold", 32'(column), 32'h6);
    step(1);
    chk("col1", 32'(column), 32'h5);
    step(8);
    chk("col2", 32'(column), 32'h3);
    step(8);
    chk("col0_wrap",  32'(column),    32'h6);
    chk("idle_valid", 32'(ev_valid),  32'd0);
    chk("idle_state", 32'(key_state), 32'd0);

    // key 5 press: samples at 48, 72, 96 -> accepted at edge 96
    held[5] = 1'b1;
    step(71);
    chk("k5_pre", 32'(key_state), 32'd0);
    step(1);
    chk("k5_state", 32'(key_state), 32'h020);
    chk("k5_nolat", 32'(ev_valid),  32'd0);
    step(1);
    chk_head("k5_press", 5, 1'b1);
    pop_one();
    chk("k5_popped", 32'(ev_valid), 32'd0);

    // key 5 release
    held[5] = 1'b0;
    step(72);
    chk("k5_rel_state", 32'(key_state), 32'd0);
    chk_head("k5_release", 5, 1'b0);
    pop_one();
    chk("k5_rel_popped", 32'(ev_valid), 32'd0);

    // key 5 closed for only two samples -> rejected
    align_scan();
    held[5] = 1'b1;
    step(48);
    held[5] = 1'b0;
    step(72);
    chk("glitch_state", 32'(key_state), 32'd0);
    chk("glitch_valid", 32'(ev_valid),  32'd0);

    // keys 0 and 3 together: column 0 samples at +8, +32, +56
    align_scan();
    held = 9'h009;
    step(56);
    chk("k03_state", 32'(key_state), 32'h009);
    chk("k03_nolat", 32'(ev_valid),  32'd0);
    step(1);
    chk_head("k03_first", 0, 1'b1);
    step(3);
    chk_head("k03_hold", 0, 1'b1);
    pop_one();
    chk_head("k03_second", 3, 1'b1);
    pop_one();
    chk("k03_empty", 32'(ev_valid), 32'd0);

    align_scan();
    held = 9'h000;
    step(60);
    chk("k03_rel_state", 32'(key_state), 32'd0);
    chk_head("k03_rel0", 0, 1'b0);
    pop_one();
    chk_head("k03_rel3", 3, 1'b0);
    pop_one();
    chk("k03_rel_empty", 32'(ev_valid), 32'd0);

    // five presses (col0: 0,3,6; col1: 1,4) into a 4-deep FIFO
    align_scan();
    held = 9'h05B;
    step(70);
    chk("ovf_state", 32'(key_state), 32'h05B);
    chk("ovf_flag",  32'(overflow),  32'd1);
    chk_head("ovf_h0", 0, 1'b1);
    pop_one();
    chk_head("ovf_h1", 3, 1'b1);
    pop_one();
    chk_head("ovf_h2", 6, 1'b1);
    pop_one();
    chk_head("ovf_h3", 1, 1'b1);
    pop_one();
    chk("ovf_empty",  32'(ev_valid), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // queue presses of keys 5 and 8, then reset mid-hold
    align_scan();
    held = 9'h17B;
    step(76);
    chk("pre_rst_state", 32'(key_state), 32'h17B);
    chk_head("pre_rst_head", 5, 1'b1);
    held  = 9'h020;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid",  32'(ev_valid),  32'd0);
    chk("mid_rst_state",  32'(key_state), 32'd0);
    chk("mid_rst_ovf",    32'(overflow),  32'd0);
    chk("mid_rst_column", 32'(column),    32'h6);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    edges = 0;

    // key 5 held across reset: samples at 24, 48, 72
    step(71);
    chk("post_rst_pre", 32'(key_state), 32'd0);
    chk("post_rst_noev", 32'(ev_valid), 32'd0);
    step(1);
    chk("post_rst_state", 32'(key_state), 32'h020);
    step(1);
    chk_head("post_rst_press", 5, 1'b1);
    chk("post_rst_ovf", 32'(overflow), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
